// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - word-size codes, FSM encodings and alignment rule
package data_mem_ctrl_pkg;

  localparam logic [2:0] BYTE_WORD     = 3'b001;
  localparam logic [2:0] HALF_WORD     = 3'b010;
  localparam logic [2:0] COMPLETE_WORD = 3'b100;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD_WAIT = 3'd1;
  localparam logic [2:0] ST_LOAD_DONE = 3'd2;
  localparam logic [2:0] ST_RMW_MERGE = 3'd3;
  localparam logic [2:0] ST_RMW_WRITE = 3'd4;

  // Unknown size codes are never legal, whatever the address.
  function automatic logic is_legal_access(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      BYTE_WORD:     return 1'b1;
      HALF_WORD:     return ~addr_lo[0];
      COMPLETE_WORD: return (addr_lo == 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lane.sv
// rtl/data_mem_ctrl_lane.sv - mem_lane_align: little-endian lane select/extend and store merge
module mem_lane_align
  import data_mem_ctrl_pkg::*;
#(
  parameter int NB = 32
) (
  input  logic [NB-1:0] i_word,
  input  logic [NB-1:0] i_data,
  input  logic [1:0]    i_addr_lo,
  input  logic [2:0]    i_size,
  input  logic          i_signed,
  output logic [NB-1:0] o_load,
  output logic [NB-1:0] o_merged
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [4:0]  byte_pos;
  logic [4:0]  half_pos;
  logic        unused_data;

  assign byte_pos    = {i_addr_lo, 3'b000};
  assign half_pos    = {i_addr_lo[1], 4'b0000};
  assign unused_data = ^i_data[NB-1:16];

  always_comb begin
    sel_byte = i_word[byte_pos +: 8];
    sel_half = i_word[half_pos +: 16];
    o_merged = i_word;
    o_load   = i_word;
    case (i_size)
      BYTE_WORD: begin
        o_load                  = {{(NB-8){i_signed & sel_byte[7]}}, sel_byte};
        o_merged[byte_pos +: 8] = i_data[7:0];
      end
      HALF_WORD: begin
        o_load                   = {{(NB-16){i_signed & sel_half[15]}}, sel_half};
        o_merged[half_pos +: 16] = i_data[15:0];
      end
      default: begin
        o_load   = i_word;
        o_merged = i_word;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - memory-stage controller: loads, stores, sub-word read-modify-write
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int NB           = 32,
  parameter int NB_SIZE_TYPE = 3,
  parameter int NB_ADDR      = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_mem_read,
  input  logic                    i_mem_write,
  input  logic                    i_signed,
  input  logic [NB_SIZE_TYPE-1:0] i_word_size,
  input  logic [NB-1:0]           i_addr,
  input  logic [NB-1:0]           i_wdata,
  output logic [NB-1:0]           o_rdata,
  output logic                    o_rdata_valid,
  output logic                    o_stall,
  output logic                    o_misaligned,
  output logic                    o_ram_en,
  output logic                    o_ram_we,
  output logic [NB_ADDR-1:0]      o_ram_addr,
  output logic [NB-1:0]           o_ram_wdata,
  input  logic [NB-1:0]           i_ram_rdata
);

  logic [2:0]    state, next_state;
  logic [NB-1:0] merge_q, load_result, merged_word, ram_wdata;
  logic          req, legal, sub_word, stall, misaligned, ram_en, ram_we;
  logic          unused_addr;

  assign req         = i_mem_read | i_mem_write;
  assign legal       = is_legal_access(i_word_size, i_addr[1:0]);
  assign sub_word    = (i_word_size != COMPLETE_WORD);
  assign unused_addr = ^i_addr[NB-1:NB_ADDR+2];

  mem_lane_align #(.NB(NB)) u_lane (
    .i_word    (i_ram_rdata),
    .i_data    (i_wdata),
    .i_addr_lo (i_addr[1:0]),
    .i_size    (i_word_size),
    .i_signed  (i_signed),
    .o_load    (load_result),
    .o_merged  (merged_word)
  );

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (!legal) begin
            misaligned = 1'b1;
          end else if (i_mem_write && !sub_word) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_wdata = i_wdata;
          end else begin
            ram_en     = 1'b1;
            stall      = 1'b1;
            next_state = i_mem_write ? ST_RMW_MERGE : ST_LOAD_WAIT;
          end
        end
      end
      ST_LOAD_WAIT: begin
        stall      = 1'b1;
        next_state = ST_LOAD_DONE;
      end
      ST_LOAD_DONE: next_state = ST_IDLE;
      ST_RMW_MERGE: begin
        stall      = 1'b1;
        next_state = ST_RMW_WRITE;
      end
      ST_RMW_WRITE: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_wdata  = merge_q;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      o_rdata <= '0;
      merge_q <= '0;
    end else begin
      state <= next_state;
      if (state == ST_LOAD_WAIT) o_rdata <= load_result;
      if (state == ST_RMW_MERGE) merge_q <= merged_word;
    end
  end

  // A held request must not reach the RAM while reset is asserted.
  assign o_stall       = i_rst_n & stall;
  assign o_misaligned  = i_rst_n & misaligned;
  assign o_ram_en      = i_rst_n & ram_en;
  assign o_ram_we      = i_rst_n & ram_we;
  assign o_ram_wdata   = i_rst_n ? ram_wdata : '0;
  assign o_ram_addr    = i_rst_n ? i_addr[NB_ADDR+1:2] : '0;
  assign o_rdata_valid = (state == ST_LOAD_DONE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, sgn;
  logic [2:0]  word_size;
  logic [31:0] addr, wdata, rdata, ram_wdata, ram_rdata;
  logic        rdata_valid, stall, misaligned, ram_en, ram_we;
  logic [9:0]  ram_addr;

  logic [31:0] ram [0:15];
  logic [7:0]  ref_mem [0:63];
  logic        bd_we = 1'b0;
  logic [3:0]  bd_addr;
  logic [31:0] bd_data;
  int          ram_writes = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mem_read(mem_read), .i_mem_write(mem_write),
    .i_signed(sgn), .i_word_size(word_size), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata), .o_rdata_valid(rdata_valid), .o_stall(stall),
    .o_misaligned(misaligned), .o_ram_en(ram_en), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (ram_en && ram_we) begin
      ram[ram_addr[3:0]] <= ram_wdata;
      ram_writes <= ram_writes + 1;
    end else if (ram_en) ram_rdata <= ram[ram_addr[3:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read = 0; mem_write = 0; sgn = 0; word_size = 3'b000; addr = 0; wdata = 0;
  endtask

  function automatic logic [31:0] word_at(input int a);
    int b;
    b = a & ~3;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic logic [31:0] exp_load(input int a, input logic [2:0] sz, input logic sg);
    logic [31:0] v;
    v = word_at(a);
    if (sz == BYTE_WORD) begin
      v = {24'd0, ref_mem[a]};
      if (sg && ref_mem[a] >= 8'h80) v = v - 32'h100;
    end else if (sz == HALF_WORD) begin
      v = {16'd0, ref_mem[a+1], ref_mem[a]};
      if (sg && ref_mem[a+1] >= 8'h80) v = v - 32'h10000;
    end
    return v;
  endfunction

  function automatic bit legal(input int a, input logic [2:0] sz);
    return (sz == BYTE_WORD) || (sz == HALF_WORD && a % 2 == 0) ||
           (sz == COMPLETE_WORD && a % 4 == 0);
  endfunction

  task automatic preload(input int widx, input logic [31:0] w);
    bd_we = 1; bd_addr = widx[3:0]; bd_data = w;
    for (int k = 0; k < 4; k++) ref_mem[widx*4+k] = w[8*k +: 8];
    next_cycle();
    bd_we = 0;
  endtask

  task automatic do_load(input int a, input logic [2:0] sz, input logic sg, input logic [31:0] exp);
    mem_read = 1; mem_write = 0; sgn = sg; word_size = sz;
    addr = ($urandom() & 32'hFFFF_F000) | a; wdata = $urandom();
    @(negedge clk);
    chk("ld_c0_stall", stall, 1); chk("ld_c0_en", ram_en, 1); chk("ld_c0_we", ram_we, 0);
    chk("ld_c0_addr", ram_addr, a >> 2);
    next_cycle(); @(negedge clk);
    chk("ld_c1_stall", stall, 1); chk("ld_c1_valid", rdata_valid, 0);
    next_cycle(); @(negedge clk);
    chk("ld_c2_stall", stall, 0); chk("ld_c2_valid", rdata_valid, 1);
    chk("ld_rdata", rdata, exp);
    next_cycle();
    idle_inputs();
  endtask

  task automatic do_store(input int a, input logic [2:0] sz, input logic [31:0] d);
    int nbytes;
    mem_read = 0; mem_write = 1; word_size = sz; sgn = $urandom_range(0, 1);
    addr = ($urandom() & 32'hFFFF_F000) | a; wdata = d;
    nbytes = (sz == BYTE_WORD) ? 1 : (sz == HALF_WORD) ? 2 : 4;
    for (int k = 0; k < nbytes; k++) ref_mem[a+k] = d[8*k +: 8];
    @(negedge clk);
    if (sz == COMPLETE_WORD) begin
      chk("sw_stall", stall, 0); chk("sw_en", ram_en, 1); chk("sw_we", ram_we, 1);
      chk("sw_wdata", ram_wdata, d); chk("sw_addr", ram_addr, a >> 2);
    end else begin
      chk("rmw_c0_stall", stall, 1); chk("rmw_c0_en", ram_en, 1); chk("rmw_c0_we", ram_we, 0);
      next_cycle(); @(negedge clk);
      chk("rmw_c1_stall", stall, 1); chk("rmw_c1_en", ram_en, 0);
      next_cycle(); @(negedge clk);
      chk("rmw_c2_stall", stall, 0); chk("rmw_c2_we", ram_we, 1); chk("rmw_c2_en", ram_en, 1);
      chk("rmw_wdata", ram_wdata, word_at(a)); chk("rmw_addr", ram_addr, a >> 2);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic do_reject(input int a, input logic [2:0] sz, input bit is_write);
    mem_read = !is_write; mem_write = is_write; word_size = sz; addr = a; wdata = $urandom();
    @(negedge clk);
    chk("rej_mis", misaligned, 1); chk("rej_en", ram_en, 0); chk("rej_stall", stall, 0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("rej_after", misaligned, 0);
    next_cycle();
  endtask

  initial begin
    int w0, a;
    logic [2:0] sz;
    logic [2:0] sizes [5];
    sizes[0] = BYTE_WORD; sizes[1] = HALF_WORD; sizes[2] = COMPLETE_WORD;
    sizes[3] = 3'b000; sizes[4] = 3'b111;
    rst_n = 0;
    idle_inputs();
    for (int i = 0; i < 16; i++) preload(i, $urandom());
    preload(4, 32'h8000_F0A5);
    @(negedge clk);
    chk("rst_rdata", rdata, 0); chk("rst_valid", rdata_valid, 0); chk("rst_stall", stall, 0);
    chk("rst_mis", misaligned, 0); chk("rst_en", ram_en, 0); chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0); chk("rst_wdata", ram_wdata, 0);
    rst_n = 1;
    next_cycle(); @(negedge clk);
    chk("nop_en", ram_en, 0); chk("nop_stall", stall, 0);
    next_cycle();

    do_load(32'h10, BYTE_WORD, 1, 32'hFFFF_FFA5);
    do_load(32'h12, HALF_WORD, 0, 32'h0000_8000);
    do_load(32'h11, BYTE_WORD, 0, 32'h0000_00F0);

    // SH interrupted by reset during RMW_MERGE
    w0 = ram_writes;
    mem_write = 1; word_size = HALF_WORD; addr = 32'h12; wdata = 32'h0000_1234;
    next_cycle();
    #1 rst_n = 0; mem_write = 0;
    #1;
    chk("rstmid_stall", stall, 0); chk("rstmid_en", ram_en, 0); chk("rstmid_we", ram_we, 0);
    chk("rstmid_wdata", ram_wdata, 0); chk("rstmid_addr", ram_addr, 0);
    chk("rstmid_rdata", rdata, 0); chk("rstmid_valid", rdata_valid, 0);
    chk("rstmid_mis", misaligned, 0);
    @(negedge clk); rst_n = 1;
    idle_inputs();
    repeat (3) next_cycle();
    chk("rstmid_nowrite", ram_writes, w0);
    do_load(32'h10, COMPLETE_WORD, 1, 32'h8000_F0A5);

    do_store(32'h11, BYTE_WORD, 32'h0000_0077);
    do_load(32'h10, COMPLETE_WORD, 0, 32'h8000_77A5);
    do_store(32'h14, COMPLETE_WORD, 32'hDEAD_BEEF);
    do_load(32'h14, COMPLETE_WORD, 1, 32'hDEAD_BEEF);

    do_reject(32'h13, HALF_WORD, 0);
    do_reject(32'h12, COMPLETE_WORD, 1);
    do_reject(32'h10, 3'b111, 0);

    for (int n = 0; n < 80; n++) begin
      a  = $urandom_range(0, 63);
      sz = sizes[$urandom_range(0, 4)];
      if (!legal(a, sz)) do_reject(a, sz, $urandom_range(0, 1));
      else if ($urandom_range(0, 1) == 1) do_store(a, sz, $urandom());
      else begin
        sgn = $urandom_range(0, 1);
        do_load(a, sz, sgn, exp_load(a, sz, sgn));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Memory-stage controller between the EX/MEM pipeline register and the word-wide synchronous data RAM. It consumes the decoded memory controls (read, write, word size, signed) and performs byte, half and word loads and stores. Sub-word stores use read-modify-write, because the RAM has no byte enables. Loads are lane-aligned and sign- or zero-extended. The block stalls the pipeline while a multi-cycle access is in flight.

## Interface
Parameters:
- NB, 32: data and byte-address width.
- NB_SIZE_TYPE, 3: width of the word-size code.
- NB_ADDR, 10: RAM word-address width.

Ports:
- i_clk, in, 1: clock; all state updates on rising edge.
- i_rst_n, in, 1: asynchronous, active-low reset.
- i_mem_read, in, 1: load request.
- i_mem_write, in, 1: store request. It has priority if both are high.
- i_signed, in, 1: loads only; 1 = sign-extend, 0 = zero-extend.
- i_word_size, in, NB_SIZE_TYPE: `COMPLETE_WORD`, `HALF_WORD` or `BYTE_WORD` from memory_constants.vh.
- i_addr, in, NB: byte address (ALU result).
- i_wdata, in, NB: store data (rt value); sub-word data is taken from the low bits.
- o_rdata, out, NB: extended load result, registered.
- o_rdata_valid, out, 1: one-cycle pulse when o_rdata holds a new load result.
- o_stall, out, 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- o_misaligned, out, 1: request rejected for misalignment or an illegal size.
- o_ram_en, out, 1: RAM access enable.
- o_ram_we, out, 1: RAM write enable.
- o_ram_addr, out, NB_ADDR: word address, i_addr[NB_ADDR+1:2].
- o_ram_wdata, out, NB: RAM write word.
- i_ram_rdata, in, NB: RAM read word, valid the cycle after an o_ram_en=1, o_ram_we=0 cycle.

## Operation
- Requests are held stable by the pipeline while o_stall=1.
- Byte lanes are little-endian.
  - Byte k sits at bits [8k+7:8k], with k = i_addr[1:0].
  - The half at i_addr[1] sits at bits [16·i_addr[1]+15 : 16·i_addr[1]].
- Alignment:
  - Half requires i_addr[0]=0.
  - Word requires i_addr[1:0]=0.
  - Any other size code is illegal.
  - A misaligned or illegal request is rejected in IDLE: o_misaligned=1 combinationally that cycle, with no RAM access, no stall and no state change.
- FSM states: IDLE, LOAD_WAIT, LOAD_DONE, RMW_MERGE, RMW_WRITE.
  - IDLE, store word: o_ram_en=1, o_ram_we=1, o_ram_wdata=i_wdata. No stall; stay in IDLE.
  - IDLE, load or sub-word store: o_ram_en=1, o_ram_we=0, o_stall=1. A load goes to LOAD_WAIT; a sub-word store goes to RMW_MERGE.
  - LOAD_WAIT: select the lane from i_ram_rdata, extend per i_signed, register into o_rdata. o_stall=1; go to LOAD_DONE.
  - LOAD_DONE: o_rdata_valid=1, o_stall=0; go to IDLE.
  - RMW_MERGE: replace the target lane of i_ram_rdata with i_wdata[7:0] or i_wdata[15:0] and register the merged word. o_stall=1; go to RMW_WRITE.
  - RMW_WRITE: o_ram_en=1, o_ram_we=1, o_ram_wdata = merged word. o_stall=0; go to IDLE.
- No new request is accepted in LOAD_DONE or RMW_WRITE; the next instruction arrives in the following IDLE cycle.
- Word loads ignore i_signed.
- A request with both mem controls low does nothing.

## Timing
- Reset (asynchronous, any state): state=IDLE; o_rdata=0; o_rdata_valid=0; o_stall=0; o_misaligned=0; o_ram_en=0; o_ram_we=0; o_ram_addr=0; o_ram_wdata=0.
- Reset mid-RMW abandons the pending write; no partial write occurs.
- Load: request cycle 0; o_stall high in cycles 0–1; o_rdata valid with o_rdata_valid=1 in cycle 2.
- Sub-word store: o_stall high in cycles 0–1; RAM write in cycle 2.
- Word store: write in cycle 0; zero stall cycles.
- o_stall is combinational from state and request. o_rdata and the merge register are flop outputs.

## Structure
- Word-size codes and alignment checks use memory_constants.vh.
- FSM state encodings go in a new data_mem_ctrl_constants.vh.
- One natural sub-module: mem_lane_align, purely combinational. It provides:
  - load lane select and extension: (word, addr[1:0], size, signed) → result;
  - store lane merge: (old word, data, addr[1:0], size) → merged word.

## Test plan
RAM word at byte address 0x10 preloaded to 0x8000_F0A5.
- LB, i_signed=1, addr 0x10 → o_stall high 2 cycles; cycle 2: o_rdata=0xFFFF_FFA5, o_rdata_valid=1.
- LHU, addr 0x12 → o_rdata=0x0000_8000. LBU, addr 0x11 → 0x0000_00F0.
- SB, addr 0x11, wdata 0x0000_0077 → one read, then one write in cycle 2; RAM word becomes 0x8000_77A5.
- SW, addr 0x14, wdata 0xDEAD_BEEF → o_ram_we=1 in cycle 0, o_stall never high. A following LW of 0x14 returns 0xDEAD_BEEF.
- LH, addr 0x13 → o_misaligned=1 for one cycle, o_ram_en=0, o_stall=0. Same check for SW at addr 0x12.
- SH, addr 0x12, with i_rst_n pulsed low during RMW_MERGE → no RAM write; all outputs 0; RAM word unchanged (0x8000_F0A5).
